// File: rtl/rxe_ctrl.sv
// rxe_ctrl - receive-path sequencer for the ethernet nibble stream.
//
// Frames packets arriving from the PHY. The preamble and SFD are stripped.
// Post-SFD nibbles are gated to the rx stages (min-length, CRC, MAC filter).
// Once a frame ends, the stage error flags are collected and one status
// record per packet is handed to the rx buffer logic over a valid/ready
// handshake.
//
// Optional feature: define RXE_STATS_EN to build the saturating good/drop
// packet counters. When it is undefined, o_stat_good and o_stat_drop are
// tied to 0.
//
// Ports:
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_ce                      nibble strobe; stream logic advances only when high
//   i_en                      receiver enable, sampled at SFD
//   i_v, i_d                  raw PHY nibble valid / data
//   i_minerr/i_crcerr/i_macerr  rx stage error flags
//   o_cancel                  one-tick abort pulse to all rx stages
//   o_v, o_d                  gated post-SFD nibble stream
//   o_pkt_stb, i_pkt_ready    status record handshake
//   o_pkt_len, o_pkt_err      frame length (bytes), {ALIGN,LONG,CRC|MAC,RUNT}
//   o_busy                    sequencer not idle
//   o_stat_good, o_stat_drop  packet statistics
module rxe_ctrl #(
    parameter int MINNIBBLES = 120,
    parameter int MAXNIBBLES = 3036,
    parameter int LGLEN      = 11,
    parameter int CHKDELAY   = 2
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_ce,
    input  logic             i_en,
    input  logic             i_v,
    input  logic [3:0]       i_d,
    input  logic             i_minerr,
    input  logic             i_crcerr,
    input  logic             i_macerr,
    output logic             o_cancel,
    output logic             o_v,
    output logic [3:0]       o_d,
    output logic             o_pkt_stb,
    input  logic             i_pkt_ready,
    output logic [LGLEN-1:0] o_pkt_len,
    output logic [3:0]       o_pkt_err,
    output logic             o_busy,
    output logic [15:0]      o_stat_good,
    output logic [15:0]      o_stat_drop
);
    localparam int            CW       = $clog2(MAXNIBBLES + 1);
    localparam logic [CW-1:0] MIN_C    = CW'(MINNIBBLES);
    localparam logic [CW-1:0] MAX_C    = CW'(MAXNIBBLES);
    localparam logic [7:0]    CHK_LAST = 8'((CHKDELAY > 0) ? CHKDELAY - 1 : 0);

    typedef enum logic [2:0] {IDLE, PREAMBLE, DATA, CHECK, REPORT, WAITEND} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [7:0]    chk;
    logic          long_pend;  // LONG record waits for the tail to drain
    logic          overrun;    // a packet started while the record was unaccepted
    logic          v_prev;     // i_v at the previous nibble strobe

    assign o_busy = (state != IDLE);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            // A tail still in flight must not be reframed as a new packet.
            state     <= i_v ? WAITEND : IDLE;
            o_cancel  <= 1'b0;
            o_v       <= 1'b0;
            o_d       <= 4'h0;
            o_pkt_stb <= 1'b0;
            o_pkt_len <= '0;
            o_pkt_err <= 4'h0;
            cnt       <= '0;
            chk       <= '0;
            long_pend <= 1'b0;
            overrun   <= 1'b0;
            v_prev    <= 1'b0;
        end else begin
            if (i_ce) begin
                o_cancel <= 1'b0;
                o_v      <= 1'b0;
                v_prev   <= i_v;
            end
            case (state)
                IDLE: if (i_ce && i_v)
                    state <= (i_d == 4'h5) ? PREAMBLE : WAITEND;
                PREAMBLE: if (i_ce) begin
                    if (!i_v)
                        state <= IDLE;
                    else if (i_d == 4'hd) begin
                        state <= i_en ? DATA : WAITEND;
                        cnt   <= '0;
                    end else if (i_d != 4'h5)
                        state <= WAITEND;
                end
                DATA: if (i_ce) begin
                    if (!i_v) begin
                        state <= CHECK;
                        chk   <= '0;
                    end else if ((cnt + CW'(1)) == MAX_C) begin
                        // Too long: abort the stages; this nibble is not forwarded.
                        cnt       <= MAX_C;
                        o_cancel  <= 1'b1;
                        long_pend <= 1'b1;
                        o_pkt_err <= 4'b0100;
                        o_pkt_len <= LGLEN'(MAX_C >> 1);
                        state     <= WAITEND;
                    end else begin
                        cnt <= cnt + CW'(1);
                        o_v <= 1'b1;
                        o_d <= i_d;
                    end
                end
                CHECK: if (i_ce) begin
                    // Stages report their verdicts a few strobes after the frame ends.
                    if (chk == CHK_LAST) begin
                        o_pkt_err <= {cnt[0], 1'b0, i_crcerr | i_macerr,
                                      i_minerr | (cnt < MIN_C)};
                        o_pkt_len <= LGLEN'(cnt >> 1);
                        o_pkt_stb <= 1'b1;
                        overrun   <= 1'b0;
                        state     <= REPORT;
                    end else
                        chk <= chk + 8'd1;
                end
                REPORT: begin
                    if (i_ce && i_v && !v_prev)
                        overrun <= 1'b1;
                    // Handshake is per clock, independent of the nibble strobe.
                    if (i_pkt_ready) begin
                        o_pkt_stb <= 1'b0;
                        overrun   <= 1'b0;
                        state     <= (i_v || overrun) ? WAITEND : IDLE;
                    end
                end
                WAITEND: if (i_ce && !i_v) begin
                    if (long_pend) begin
                        long_pend <= 1'b0;
                        overrun   <= 1'b0;
                        o_pkt_stb <= 1'b1;
                        state     <= REPORT;
                    end else
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RXE_STATS_EN
    logic       hs;
    logic [1:0] ndrop;
    logic [16:0] drop_sum;

    assign hs       = o_pkt_stb & i_pkt_ready;
    // A rejected record and an overrun can retire on the same handshake.
    assign ndrop    = {1'b0, hs && (o_pkt_err != 4'h0)} + {1'b0, hs && overrun};
    assign drop_sum = {1'b0, o_stat_drop} + 17'(ndrop);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_stat_good <= 16'h0;
            o_stat_drop <= 16'h0;
        end else begin
            if (hs && (o_pkt_err == 4'h0) && (o_stat_good != 16'hffff))
                o_stat_good <= o_stat_good + 16'd1;
            o_stat_drop <= drop_sum[16] ? 16'hffff : drop_sum[15:0];
        end
    end
`else
    assign o_stat_good = 16'h0;
    assign o_stat_drop = 16'h0;
`endif
endmodule

// File: tb/tb_rxe_ctrl.sv
module tb_rxe_ctrl;
`ifdef RXE_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_ce = 1'b0, i_en = 1'b1, i_v = 1'b0;
    logic [3:0]  i_d = 4'h0;
    logic        i_minerr = 1'b0, i_crcerr = 1'b0, i_macerr = 1'b0;
    logic        i_pkt_ready = 1'b1;
    logic        o_cancel, o_v, o_pkt_stb, o_busy;
    logic [3:0]  o_d, o_pkt_err;
    logic [10:0] o_pkt_len;
    logic [15:0] o_stat_good, o_stat_drop;

    rxe_ctrl dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_ce(i_ce), .i_en(i_en),
        .i_v(i_v), .i_d(i_d), .i_minerr(i_minerr), .i_crcerr(i_crcerr),
        .i_macerr(i_macerr), .o_cancel(o_cancel), .o_v(o_v), .o_d(o_d),
        .o_pkt_stb(o_pkt_stb), .i_pkt_ready(i_pkt_ready), .o_pkt_len(o_pkt_len),
        .o_pkt_err(o_pkt_err), .o_busy(o_busy), .o_stat_good(o_stat_good),
        .o_stat_drop(o_stat_drop)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [10:0] len;
        logic [3:0]  err;
    } rec_t;

    rec_t       rec_q[$];
    logic [3:0] nib_q[$];
    int n_checks = 0, n_fail = 0;
    int ov_cnt = 0, cancel_cnt = 0, cancel_idx = 0, cur_idx = 0;
    int exp_good = 0, exp_drop = 0;
    logic        prev_stb = 1'b0, prev_rdy = 1'b0;
    logic [10:0] prev_len = '0;
    logic [3:0]  prev_err = '0;

    // One clock; records are scored just before the edge that accepts them.
    task automatic cyc();
        rec_t r;
        @(negedge i_clk);
        if (i_reset) prev_stb = 1'b0;
        else begin
            if (o_pkt_stb && i_pkt_ready) begin
                n_checks++;
                if (rec_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_record len=%0d err=%b", o_pkt_len, o_pkt_err);
                end else begin
                    r = rec_q.pop_front();
                    if (o_pkt_len !== r.len || o_pkt_err !== r.err) begin
                        n_fail++;
                        $display("FAIL record got len=%0d err=%b, required len=%0d err=%b",
                                 o_pkt_len, o_pkt_err, r.len, r.err);
                    end
                end
            end
            if (prev_stb && !prev_rdy) begin
                n_checks++;
                if (o_pkt_stb !== 1'b1 || o_pkt_len !== prev_len || o_pkt_err !== prev_err) begin
                    n_fail++;
                    $display("FAIL record_hold got stb=%b len=%0d err=%b, required 1 %0d %b",
                             o_pkt_stb, o_pkt_len, o_pkt_err, prev_len, prev_err);
                end
            end
            prev_stb = o_pkt_stb; prev_rdy = i_pkt_ready;
            prev_len = o_pkt_len; prev_err = o_pkt_err;
        end
        @(posedge i_clk);
        #1;
    endtask

    // One nibble strobe followed by one idle clock.
    task automatic nib(input logic v, input logic [3:0] d);
        logic [3:0] e;
        i_v = v; i_d = d; i_ce = 1'b1;
        cyc();
        i_ce = 1'b0;
        if (o_v) begin
            ov_cnt++;
            n_checks++;
            if (nib_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_o_v o_d=%h", o_d);
            end else begin
                e = nib_q.pop_front();
                if (o_d !== e) begin
                    n_fail++;
                    $display("FAIL o_d got %h, required %h", o_d, e);
                end
            end
        end
        if (o_cancel) begin
            cancel_cnt++;
            cancel_idx = cur_idx;
        end
        cyc();
    endtask

    task automatic send(input int n, input bit fwd, input int abort_at,
                        input int rdy_at, input bit nostb);
        logic [3:0] d;
        for (int i = 0; i < 15; i++) nib(1'b1, 4'h5);
        nib(1'b1, 4'hd);
        for (int i = 1; i <= n; i++) begin
            d = 4'($urandom);
            cur_idx = i;
            if (fwd && (abort_at == 0 || i < abort_at)) nib_q.push_back(d);
            if (i == rdy_at) i_pkt_ready = 1'b1;
            nib(1'b1, d);
        end
        cur_idx = 0;
        if (nostb) begin
            n_checks++;
            if (o_pkt_stb !== 1'b0) begin
                n_fail++;
                $display("FAIL early_record stb=%b before i_v fell, required 0", o_pkt_stb);
            end
        end
        nib(1'b0, 4'h0);
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while ((rec_q.size() != 0 || o_busy !== 1'b0) && k < 400) begin
            nib(1'b0, 4'h0);
            k++;
        end
        n_checks++;
        if (rec_q.size() != 0 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_drain pending=%0d busy=%b, required 0 0", tag, rec_q.size(), o_busy);
        end
        n_checks++;
        if (nib_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_nibbles %0d never forwarded, required 0", tag, nib_q.size());
        end
    endtask

    task automatic chk_ov(input string tag, input int exp);
        n_checks++;
        if (ov_cnt != exp) begin
            n_fail++;
            $display("FAIL %s_ov_count got %0d, required %0d", tag, ov_cnt, exp);
        end
        ov_cnt = 0;
    endtask

    task automatic chk_stats(input string tag);
        n_checks++;
        if (o_stat_good !== 16'(exp_good) || o_stat_drop !== 16'(exp_drop)) begin
            n_fail++;
            $display("FAIL %s_stats got good=%0d drop=%0d, required %0d %0d",
                     tag, o_stat_good, o_stat_drop, exp_good, exp_drop);
        end
    endtask

    task automatic test_reset();
        i_reset = 1'b1; i_v = 1'b0;
        cyc(); cyc();
        i_reset = 1'b0;
        n_checks++;
        if ({o_busy, o_v, o_d, o_cancel, o_pkt_stb, o_pkt_len, o_pkt_err} !== '0 ||
            o_stat_good !== 16'h0 || o_stat_drop !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_state busy=%b v=%b d=%h cancel=%b stb=%b len=%0d err=%b good=%0d drop=%0d, required all 0",
                     o_busy, o_v, o_d, o_cancel, o_pkt_stb, o_pkt_len, o_pkt_err, o_stat_good, o_stat_drop);
        end
    endtask

    task automatic test_good();
        i_pkt_ready = 1'b1;
        rec_q.push_back('{len: 11'd64, err: 4'b0000});
        send(128, 1'b1, 0, -1, 1'b1);
        wait_done("good");
        chk_ov("good", 128);
        exp_good += STATS;
        chk_stats("good");
    endtask

    task automatic test_runt();
        i_minerr = 1'b1;
        rec_q.push_back('{len: 11'd50, err: 4'b0001});
        send(100, 1'b1, 0, -1, 1'b1);
        wait_done("runt");
        i_minerr = 1'b0;
        chk_ov("runt", 100);
        exp_drop += STATS;
        chk_stats("runt");
    endtask

    task automatic test_long();
        cancel_cnt = 0; cancel_idx = 0;
        rec_q.push_back('{len: 11'd1518, err: 4'b0100});
        send(3040, 1'b1, 3036, -1, 1'b1);
        wait_done("long");
        chk_ov("long", 3035);
        n_checks++;
        if (cancel_cnt != 1 || cancel_idx != 3036) begin
            n_fail++;
            $display("FAIL long_cancel got %0d pulses at nibble %0d, required 1 at 3036",
                     cancel_cnt, cancel_idx);
        end
        exp_drop += STATS;
        chk_stats("long");
    endtask

    task automatic test_overrun();
        i_pkt_ready = 1'b0;
        rec_q.push_back('{len: 11'd64, err: 4'b0000});
        send(128, 1'b1, 0, -1, 1'b1);
        repeat (4) nib(1'b0, 4'h0);
        repeat (20) cyc();
        n_checks++;
        if (o_pkt_stb !== 1'b1 || o_pkt_len !== 11'd64) begin
            n_fail++;
            $display("FAIL overrun_hold got stb=%b len=%0d, required 1 64", o_pkt_stb, o_pkt_len);
        end
        chk_ov("overrun_pkt1", 128);
        // second packet arrives while the record is still pending
        send(128, 1'b0, 0, 60, 1'b0);
        wait_done("overrun");
        chk_ov("overrun_pkt2", 0);
        exp_good += STATS;
        exp_drop += STATS;
        chk_stats("overrun");
    endtask

    task automatic test_en_off();
        i_en = 1'b0;
        send(128, 1'b0, 0, -1, 1'b1);
        wait_done("en_off");
        chk_ov("en_off", 0);
        i_en = 1'b1;
        rec_q.push_back('{len: 11'd64, err: 4'b1000});
        send(129, 1'b1, 0, -1, 1'b1);
        wait_done("align");
        chk_ov("align", 129);
        exp_drop += STATS;
        chk_stats("align");
    endtask

    task automatic test_reset_mid();
        logic [3:0] d;
        for (int i = 0; i < 15; i++) nib(1'b1, 4'h5);
        nib(1'b1, 4'hd);
        for (int i = 0; i < 50; i++) begin
            d = 4'($urandom);
            nib_q.push_back(d);
            nib(1'b1, d);
        end
        i_v = 1'b1; i_d = 4'h5; i_reset = 1'b1;
        cyc();
        i_reset = 1'b0;
        exp_good = 0; exp_drop = 0;
        chk_stats("reset_mid");
        // the tail looks like a fresh preamble+SFD; it must stay unframed
        for (int i = 0; i < 40; i++) nib(1'b1, (i % 16 == 15) ? 4'hd : 4'h5);
        n_checks++;
        if (o_busy !== 1'b1 || o_pkt_stb !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_waitend got busy=%b stb=%b, required 1 0", o_busy, o_pkt_stb);
        end
        nib(1'b0, 4'h0);
        n_checks++;
        if (o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_idle got busy=%b, required 0", o_busy);
        end
        chk_ov("reset_mid", 50);
        rec_q.push_back('{len: 11'd64, err: 4'b0000});
        send(128, 1'b1, 0, -1, 1'b1);
        wait_done("reset_mid_next");
        chk_ov("reset_mid_next", 128);
        exp_good += STATS;
        chk_stats("reset_mid_next");
    endtask

    initial begin
        test_reset();
        test_good();
        test_runt();
        test_long();
        test_overrun();
        test_en_off();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired, required completion");
        $fatal(1, "timeout");
    end
endmodule
